// File: rtl/plic_irq_gateway.sv
// plic_irq_gateway: conditions raw external interrupt lines for the PLIC.
// Per source: polarity correction, multi-flop synchronisation into CLK,
// then either level pass-through or rising-edge capture into a saturating
// pending-edge counter that is drained by software completions. Edges lost
// to counter saturation raise a sticky per-source overflow flag.
module plic_irq_gateway #(
    parameter int unsigned          N_INT_SRC   = 32,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter int unsigned          CNT_W       = 3,
    parameter logic [N_INT_SRC-1:0] EDGE_MASK   = '0,
    parameter logic [N_INT_SRC-1:0] POLARITY    = '0
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic [N_INT_SRC-1:0] w_irq_in,
    input  logic [N_INT_SRC-1:0] w_cmpl,
    input  logic [N_INT_SRC-1:0] w_ovf_clr,
    output logic [N_INT_SRC-1:0] w_int_src,
    output logic [N_INT_SRC-1:0] w_ovf
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Synchroniser chain, stage 0 takes the polarity-corrected raw lines.
    logic [N_INT_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_INT_SRC-1:0] s;
    logic [N_INT_SRC-1:0] s_d;
    logic [N_INT_SRC-1:0] r_lvl;

    // Edge-source bookkeeping.
    logic [CNT_W-1:0]     cnt_q [N_INT_SRC];
    logic [CNT_W-1:0]     cnt_d [N_INT_SRC];
    logic [N_INT_SRC-1:0] ovf_q;
    logic [N_INT_SRC-1:0] ovf_d;
    logic [N_INT_SRC-1:0] ovf_set;
    logic [N_INT_SRC-1:0] rise;
    logic [N_INT_SRC-1:0] cmpl_e;

    assign s = sync_q[SYNC_STAGES-1];

    // Level sources never see edges or completions, so their counters and
    // overflow bits stay at reset and the unused logic folds away.
    assign rise   = s & ~s_d & EDGE_MASK;
    assign cmpl_e = w_cmpl & EDGE_MASK;

    // Synchronise the corrected inputs into CLK.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= w_irq_in ^ POLARITY;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Delayed copy for edge detection and the level-source output register.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            s_d   <= '0;
            r_lvl <= '0;
        end else begin
            s_d   <= s;
            r_lvl <= s;
        end
    end

    // Next pending-edge count and overflow set, first matching case wins.
    // A rise coinciding with a completion cancels out when edges are pending;
    // at zero it falls through to the increment so no edge is lost.
    always_comb begin
        ovf_set = '0;
        for (int unsigned i = 0; i < N_INT_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (rise[i] && cmpl_e[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i];
            end else if (rise[i] && (cnt_q[i] == CNT_MAX)) begin
                ovf_set[i] = 1'b1;
            end else if (rise[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (cmpl_e[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    // Sticky overflow: a new set wins over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~w_ovf_clr);
    end

    // Counter and overflow registers.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int unsigned i = 0; i < N_INT_SRC; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_INT_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    // Request output: level register or "edges still pending".
    always_comb begin
        w_int_src = '0;
        for (int unsigned i = 0; i < N_INT_SRC; i++) begin
            w_int_src[i] = EDGE_MASK[i] ? (cnt_q[i] != '0) : r_lvl[i];
        end
    end

    assign w_ovf = ovf_q;

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Bench for plic_irq_gateway: 4 sources, 2-stage sync, 2-bit counters,
// sources 1/2 edge-triggered, source 3 active-low.
module tb_plic_irq_gateway;

    localparam int         NS   = 4;
    localparam int         SYNC = 2;
    localparam int         PMAX = 3;
    localparam logic [3:0] EM   = 4'b0110;
    localparam logic [3:0] POL  = 4'b1000;

    logic       CLK   = 1'b0;
    logic       RST_X = 1'b1;
    logic [3:0] w_irq_in;
    logic [3:0] w_cmpl;
    logic [3:0] w_ovf_clr;
    logic [3:0] w_int_src;
    logic [3:0] w_ovf;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    plic_irq_gateway #(
        .N_INT_SRC  (4),
        .SYNC_STAGES(2),
        .CNT_W      (2),
        .EDGE_MASK  (EM),
        .POLARITY   (POL)
    ) dut (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .w_irq_in (w_irq_in),
        .w_cmpl   (w_cmpl),
        .w_ovf_clr(w_ovf_clr),
        .w_int_src(w_int_src),
        .w_ovf    (w_ovf)
    );

    always #5 CLK = ~CLK;

    // Model: pending edges as plain integers, input sample history for latency.
    int      pend [NS];
    bit      movf [NS];
    bit      mlvl [NS];
    bit [3:0] hist [SYNC+1];   // hist[0] = active-high input sampled at latest edge

    always @(posedge CLK or negedge RST_X) begin : model
        bit [3:0] a_now;
        bit [3:0] s_now;
        bit [3:0] s_old;
        bit       rs;
        bit       cp;
        bit       set;
        if (!RST_X) begin
            for (int i = 0; i < NS; i++) begin
                pend[i] = 0; movf[i] = 0; mlvl[i] = 0;
            end
            for (int k = 0; k <= SYNC; k++) hist[k] = '0;
        end else begin
            a_now = w_irq_in ^ POL;
            s_now = hist[SYNC-1];
            s_old = hist[SYNC];
            for (int i = 0; i < NS; i++) begin
                mlvl[i] = s_now[i];
                if (EM[i]) begin
                    rs  = s_now[i] && !s_old[i];
                    cp  = w_cmpl[i];
                    set = 0;
                    if (rs && cp && pend[i] > 0) begin
                        // a new edge replaces the completed one
                    end else if (rs) begin
                        if (pend[i] == PMAX) set = 1;
                        else pend[i] = pend[i] + 1;
                    end else if (cp && pend[i] > 0) begin
                        pend[i] = pend[i] - 1;
                    end
                    movf[i] = set || (movf[i] && !w_ovf_clr[i]);
                end
            end
            for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = a_now;
        end
    end

    function automatic logic [3:0] exp_int();
        logic [3:0] r;
        for (int i = 0; i < NS; i++) r[i] = EM[i] ? (pend[i] != 0) : mlvl[i];
        return r;
    endfunction

    function automatic logic [3:0] exp_ovf();
        logic [3:0] r;
        for (int i = 0; i < NS; i++) r[i] = movf[i];
        return r;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            n_cmp++;
            if (w_int_src !== exp_int()) begin
                n_err++;
                $display("FAIL model_int_src t=%0t actual=%b required=%b", $time, w_int_src, exp_int());
            end
            n_cmp++;
            if (w_ovf !== exp_ovf()) begin
                n_err++;
                $display("FAIL model_ovf t=%0t actual=%b required=%b", $time, w_ovf, exp_ovf());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic pulse(input int i);
        w_irq_in[i] = 1'b1;
        tick(4);
        w_irq_in[i] = 1'b0;
        tick(4);
    endtask

    task automatic cmpl(input int i);
        w_cmpl[i] = 1'b1;
        tick(1);
        w_cmpl[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1);
    end

    initial begin
        w_irq_in  = 4'b1000;
        w_cmpl    = '0;
        w_ovf_clr = '0;
        #1 RST_X = 1'b0;
        #1;
        check("reset_int_src", 32'(w_int_src), 32'h0);
        check("reset_ovf", 32'(w_ovf), 32'h0);
        chk_en = 1'b1;
        tick(3);
        RST_X = 1'b1;
        tick(2);

        // Level, active-high source 0.
        w_irq_in[0] = 1'b1;
        tick(2); check("lvl0_edge2", 32'(w_int_src[0]), 32'd0);
        tick(1); check("lvl0_edge3", 32'(w_int_src[0]), 32'd1);
        cmpl(0); check("lvl0_cmpl_ignored", 32'(w_int_src[0]), 32'd1);
        w_irq_in[0] = 1'b0;
        tick(2); check("lvl0_fall_edge2", 32'(w_int_src[0]), 32'd1);
        tick(1); check("lvl0_fall_edge3", 32'(w_int_src[0]), 32'd0);
        cmpl(0); check("lvl0_cmpl_low", 32'(w_int_src[0]), 32'd0);

        // Active-low level source 3.
        w_irq_in[3] = 1'b0;
        tick(2); check("lvl3_edge2", 32'(w_int_src[3]), 32'd0);
        tick(1); check("lvl3_edge3", 32'(w_int_src[3]), 32'd1);
        w_irq_in[3] = 1'b1;
        tick(2); check("lvl3_rel_edge2", 32'(w_int_src[3]), 32'd1);
        tick(1); check("lvl3_rel_edge3", 32'(w_int_src[3]), 32'd0);

        // Edge counting and completion on source 1.
        w_irq_in[1] = 1'b1;
        tick(2); check("edge1_lat2", 32'(w_int_src[1]), 32'd0);
        tick(1); check("edge1_lat3", 32'(w_int_src[1]), 32'd1);
        tick(1); w_irq_in[1] = 1'b0; tick(4);
        pulse(1); pulse(1);
        check("pend1_three", 32'(pend[1]), 32'd3);
        check("edge1_req", 32'(w_int_src[1]), 32'd1);
        cmpl(1); check("pend1_two", 32'(pend[1]), 32'd2); check("edge1_req_c1", 32'(w_int_src[1]), 32'd1);
        cmpl(1); check("pend1_one", 32'(pend[1]), 32'd1); check("edge1_req_c2", 32'(w_int_src[1]), 32'd1);
        cmpl(1); check("pend1_zero", 32'(pend[1]), 32'd0); check("edge1_req_c3", 32'(w_int_src[1]), 32'd0);
        cmpl(1); check("pend1_no_underflow", 32'(pend[1]), 32'd0); check("edge1_req_c4", 32'(w_int_src[1]), 32'd0);

        // Saturation and overflow on source 2.
        pulse(2); pulse(2); pulse(2);
        check("ovf2_before_sat", 32'(w_ovf[2]), 32'd0);
        pulse(2);
        check("ovf2_set", 32'(w_ovf[2]), 32'd1);
        check("pend2_sat", 32'(pend[2]), 32'd3);
        w_irq_in[2] = 1'b1;
        tick(2); w_ovf_clr[2] = 1'b1;
        tick(1); w_ovf_clr[2] = 1'b0;
        check("ovf2_set_beats_clr", 32'(w_ovf[2]), 32'd1);
        w_irq_in[2] = 1'b0; tick(4);
        check("edge2_req_sat", 32'(w_int_src[2]), 32'd1);
        w_ovf_clr[2] = 1'b1; tick(1); w_ovf_clr[2] = 1'b0;
        check("ovf2_cleared", 32'(w_ovf[2]), 32'd0);

        // Rise coinciding with completion: at cnt=2 and at cnt=0.
        pulse(1); pulse(1);
        w_irq_in[1] = 1'b1;
        tick(2); w_cmpl[1] = 1'b1;
        tick(1); w_cmpl[1] = 1'b0;
        check("pend1_coinc_nz", 32'(pend[1]), 32'd2);
        w_irq_in[1] = 1'b0; tick(4);
        cmpl(1); check("coinc_nz_drain1", 32'(w_int_src[1]), 32'd1);
        cmpl(1); check("coinc_nz_drain2", 32'(w_int_src[1]), 32'd0);
        w_irq_in[1] = 1'b1;
        tick(2); w_cmpl[1] = 1'b1;
        tick(1); w_cmpl[1] = 1'b0;
        check("pend1_coinc_zero", 32'(pend[1]), 32'd1);
        check("coinc_zero_req", 32'(w_int_src[1]), 32'd1);
        w_irq_in[1] = 1'b0; tick(4);
        cmpl(1); check("coinc_zero_drain", 32'(w_int_src[1]), 32'd0);

        // Asynchronous reset mid-operation, released with line 1 high.
        pulse(1); pulse(1); pulse(2);
        check("pre_rst_pend1", 32'(pend[1]), 32'd2);
        check("pre_rst_ovf2", 32'(w_ovf[2]), 32'd1);
        w_irq_in[1] = 1'b1;
        @(posedge CLK); #3 RST_X = 1'b0;
        #1;
        check("async_rst_int_src", 32'(w_int_src), 32'h0);
        check("async_rst_ovf", 32'(w_ovf), 32'h0);
        tick(2);
        RST_X = 1'b1;
        tick(4);
        check("post_rst_pend1", 32'(pend[1]), 32'd1);
        check("post_rst_req1", 32'(w_int_src[1]), 32'd1);
        tick(5);
        check("post_rst_held", 32'(w_int_src[1]), 32'd1);
        cmpl(1);
        check("post_rst_single_edge", 32'(w_int_src[1]), 32'd0);
        w_irq_in[1] = 1'b0;
        tick(4);

        chk_en = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
